rr_mux8_arbiter: RTL



---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/rr_mux8_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 8-requester round-robin mux arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // One-hot encode a requester index into an 8-bit grant vector.
    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set req bit searching upward from last_owner+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is pending.
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_owner,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk the eight positions after last_owner; the previous owner is checked
    // last so it only wins again when nobody else is asking.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = last_owner;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_owner + SEL_W'(i);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin grant sequencer driving the 8:1 mux selector; optional per-requester grant stats (MUX_ARB_STATS_EN).
// Latency: req to gnt/sel is 1 cycle; release to next grant is 2 cycles (one forced gap cycle).
// Backpressure: requesters hold req level until granted; owner keeps the grant until done, req drop or HOLD_MAX cycles.
module rr_mux8_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             timeout
`ifdef MUX_ARB_STATS_EN
    ,
    input  logic [SEL_W-1:0] stat_idx,
    output logic [15:0]      stat_cnt
`endif
);

    // Last cycle an owner may hold before a forced release.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             sel_valid_d;
    logic             timeout_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    logic             own_done;
    logic             own_req;
    logic             at_limit;

    // Single arbiter shared by IDLE and GAP; it always rotates from the last owner.
    rr_priority_pick u_pick (
        .req        (req),
        .last_owner (owner_q),
        .winner     (pick_idx),
        .any        (pick_any)
    );

    assign own_done = done[owner_q];
    assign own_req  = req[owner_q];
    assign at_limit = (hold_q == HOLD_LAST);

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        gnt_d       = '0;
        sel_d       = sel;
        sel_valid_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d     = OWN;
                    owner_d     = pick_idx;
                    hold_d      = '0;
                    gnt_d       = onehot8(pick_idx);
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            OWN: begin
                if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
                if (own_done || !own_req || at_limit) begin
                    // sel stays on the old owner through the gap so the mux
                    // never switches inside a transfer.
                    state_d   = GAP;
                    timeout_d = at_limit && own_req && !own_done;
                end else begin
                    gnt_d       = onehot8(owner_q);
                    sel_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks last owner at 7 so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 3'd7;
            hold_q    <= '0;
            gnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            timeout   <= timeout_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic        grant_now;
    logic [15:0] grant_cnt [N_REQ];

    assign grant_now = (state_q != OWN) && pick_any;

    // Saturating per-requester grant counters and registered readout port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            if (grant_now && (grant_cnt[pick_idx] != 16'hFFFF)) begin
                grant_cnt[pick_idx] <= grant_cnt[pick_idx] + 16'd1;
            end
            stat_cnt <= grant_cnt[stat_idx];
        end
    end
`endif

endmodule
